// File: rtl/seq_lamp_receiver_pkg.sv
// Shared types and constants for the lamp-sequencer receiver: FSM states,
// field widths and the io_in/io_out pin map of the user module.
package seq_lamp_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam int unsigned LAMP_W = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned ERR_W  = 3;
  localparam int unsigned HOLD_W = 4;
  localparam int unsigned CNT_W  = 3;

  // io_in fields
  localparam int unsigned PIN_CLK     = 0;
  localparam int unsigned PIN_RST     = 1;
  localparam int unsigned PIN_LAMP_LO = 2;
  localparam int unsigned PIN_LAMP_HI = 5;
  localparam int unsigned PIN_SAMPLE  = 6;
  localparam int unsigned PIN_ERR_CLR = 7;

  // io_out fields
  localparam int unsigned PIN_IDX_LO    = 0;
  localparam int unsigned PIN_IDX_HI    = 1;
  localparam int unsigned PIN_LOCKED    = 2;
  localparam int unsigned PIN_ERR_PULSE = 3;
  localparam int unsigned PIN_ERR_LO    = 4;
  localparam int unsigned PIN_ERR_HI    = 6;
  localparam int unsigned PIN_ADV       = 7;

endpackage

// File: rtl/seq_lamp_receiver_if.sv
// Standard 8-bit user-module pin bundle; io_in carries clock and reset too.
interface seq_lamp_receiver_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/seq_lamp_receiver_decoder.sv
// Combinational one-hot lamp decoder: exactly one lamp lit gives its index.
module lamp_onehot_decoder
  import seq_lamp_pkg::*;
(
  input  logic [LAMP_W-1:0] lamps,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    unique case (lamps)
      4'b0001: begin idx = 2'd0; valid = 1'b1; end
      4'b0010: begin idx = 2'd1; valid = 1'b1; end
      4'b0100: begin idx = 2'd2; valid = 1'b1; end
      4'b1000: begin idx = 2'd3; valid = 1'b1; end
      default: begin idx = '0;   valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/seq_lamp_receiver.sv
// Lamp sequencer receiver: tracks phase advances 0->1->2->3->0, declares lock
// after LOCK_COUNT legal advances, and counts protocol errors while locked.
module seq_lamp_receiver
  import seq_lamp_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MAX_HOLD   = 15
) (
  seq_lamp_receiver_if.slave pins
);

  localparam logic [CNT_W-1:0]  LOCK_V   = CNT_W'(LOCK_COUNT);
  localparam logic [HOLD_W-1:0] MAX_HOLD_V = HOLD_W'(MAX_HOLD);
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  logic              clk, rst, sample_en, err_clr;
  logic [LAMP_W-1:0] lamps;

  assign clk       = pins.io_in[PIN_CLK];
  assign rst       = pins.io_in[PIN_RST];
  assign lamps     = pins.io_in[PIN_LAMP_HI:PIN_LAMP_LO];
  assign sample_en = pins.io_in[PIN_SAMPLE];
  assign err_clr   = pins.io_in[PIN_ERR_CLR];

  logic [IDX_W-1:0] dec_idx;
  logic             dec_valid;

  lamp_onehot_decoder u_dec (
    .lamps (lamps),
    .idx   (dec_idx),
    .valid (dec_valid)
  );

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  last_idx_q, last_idx_d;
  logic [CNT_W-1:0]  good_cnt_q, good_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              err_pulse_q, err_pulse_d;
  logic              adv_pulse_q, adv_pulse_d;

  logic              is_adv, is_hold, err_evt;
  logic [HOLD_W-1:0] hold_inc;
  logic [CNT_W-1:0]  good_inc;
  logic [ERR_W-1:0]  err_base;

  assign is_adv   = dec_valid && (dec_idx == last_idx_q + IDX_W'(1));
  assign is_hold  = dec_valid && (dec_idx == last_idx_q);
  assign hold_inc = hold_cnt_q + HOLD_W'(1);
  assign good_inc = good_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    last_idx_d  = last_idx_q;
    good_cnt_d  = good_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    adv_pulse_d = 1'b0;
    err_evt     = 1'b0;
    if (sample_en) begin
      unique case (state_q)
        HUNT: begin
          if (dec_valid) begin
            last_idx_d = dec_idx;
            good_cnt_d = '0;
            hold_cnt_d = '0;
            state_d    = CONFIRM;
          end
        end
        CONFIRM: begin
          if (is_adv) begin
            last_idx_d = dec_idx;
            hold_cnt_d = '0;
            good_cnt_d = good_inc;
            if (good_inc == LOCK_V) state_d = LOCKED;
          end else if (is_hold) begin
            if (hold_inc == MAX_HOLD_V) begin
              state_d    = HUNT;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_inc;
            end
          end else begin
            state_d    = HUNT;
            hold_cnt_d = '0;
            if (dec_valid) last_idx_d = dec_idx;
          end
        end
        LOCKED: begin
          if (is_adv) begin
            last_idx_d  = dec_idx;
            hold_cnt_d  = '0;
            adv_pulse_d = 1'b1;
          end else if (is_hold && (hold_inc != MAX_HOLD_V)) begin
            hold_cnt_d = hold_inc;
          end else begin
            // stall or bad code: last_idx deliberately keeps its old value
            err_evt    = 1'b1;
            state_d    = HUNT;
            hold_cnt_d = '0;
          end
        end
        default: begin
          state_d    = HUNT;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  // Clear takes effect before a same-edge increment.
  always_comb begin
    err_base    = err_clr ? '0 : err_cnt_q;
    err_cnt_d   = err_base;
    err_pulse_d = err_evt;
    if (err_evt && (err_base != ERR_MAX)) err_cnt_d = err_base + ERR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      last_idx_q  <= '0;
      good_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      adv_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_idx_q  <= last_idx_d;
      good_cnt_q  <= good_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      adv_pulse_q <= adv_pulse_d;
    end
  end

  always_comb begin
    pins.io_out                           = '0;
    pins.io_out[PIN_IDX_HI:PIN_IDX_LO]    = last_idx_q;
    pins.io_out[PIN_LOCKED]               = (state_q == LOCKED);
    pins.io_out[PIN_ERR_PULSE]            = err_pulse_q;
    pins.io_out[PIN_ERR_HI:PIN_ERR_LO]    = err_cnt_q;
    pins.io_out[PIN_ADV]                  = adv_pulse_q;
  end

endmodule

// File: tb/tb_seq_lamp_receiver.sv
// Scoreboard bench for seq_lamp_receiver: directed scenarios plus random
// lamp traffic, checked against a phase-level reference model.
module tb_seq_lamp_receiver;

  localparam int LOCK_COUNT = 4;
  localparam int MAX_HOLD   = 15;

  typedef struct {
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  logic       clk     = 1'b0;
  logic       rst_r   = 1'b1;
  logic       se_r    = 1'b0;
  logic       clr_r   = 1'b0;
  logic [3:0] lamps_r = 4'b0000;

  seq_lamp_receiver_if ifc ();
  assign ifc.io_in = {clr_r, se_r, lamps_r, rst_r, clk};

  seq_lamp_receiver #(.LOCK_COUNT(LOCK_COUNT), .MAX_HOLD(MAX_HOLD)) dut (.pins(ifc));

  always #5 clk = ~clk;

  // Reference model: phase tracking in plain integers.
  int m_mode;   // 0 searching, 1 confirming, 2 locked
  int m_last, m_good, m_hold, m_err;
  bit m_errp, m_advp;

  task automatic model_reset();
    m_mode = 0; m_last = 0; m_good = 0; m_hold = 0; m_err = 0;
    m_errp = 0; m_advp = 0;
  endtask

  task automatic model_step(input logic [3:0] l, input bit se, input bit clr);
    int  idx;
    bit  v, adv, hold, err;
    err    = 0;
    m_errp = 0;
    m_advp = 0;
    v   = ($countones(l) == 1);
    idx = v ? $clog2(l) : -1;
    adv  = v && (idx == (m_last + 1) % 4);
    hold = v && (idx == m_last);
    if (se) begin
      if (m_mode == 0) begin
        if (v) begin m_last = idx; m_good = 0; m_hold = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (adv) begin
          m_last = idx; m_hold = 0; m_good++;
          if (m_good == LOCK_COUNT) m_mode = 2;
        end else if (hold) begin
          m_hold++;
          if (m_hold == MAX_HOLD) begin m_mode = 0; m_hold = 0; end
        end else begin
          m_mode = 0; m_hold = 0;
          if (v) m_last = idx;
        end
      end else begin
        if (adv) begin
          m_last = idx; m_hold = 0; m_advp = 1;
        end else if (hold) begin
          m_hold++;
          if (m_hold == MAX_HOLD) begin err = 1; m_mode = 0; m_hold = 0; end
        end else begin
          err = 1; m_mode = 0; m_hold = 0;
        end
      end
    end
    if (clr) m_err = 0;
    if (err) begin
      m_errp = 1;
      if (m_err < 7) m_err++;
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [7:0] o;
    o[1:0] = 2'(m_last);
    o[2]   = (m_mode == 2);
    o[3]   = m_errp;
    o[6:4] = 3'(m_err);
    o[7]   = m_advp;
    return o;
  endfunction

  // One clock of stimulus: drive at the falling edge, queue the expected
  // output for the following rising edge.
  task automatic cycle(input logic [3:0] l, input bit se, input bit clr,
                       input bit rst, input string tag, input bit chk_async = 0);
    exp_t e;
    @(negedge clk);
    lamps_r = l; se_r = se; clr_r = clr; rst_r = rst;
    if (chk_async) begin
      #1;
      checks++;
      if (ifc.io_out === 8'h00) passes++;
      else $display("FAIL %s_async: io_out=%02h expected 00", tag, ifc.io_out);
    end
    if (rst) model_reset();
    else model_step(l, se, clr);
    e.exp = model_out();
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic lock_seq(input string tag);
    cycle(4'b0001, 1, 0, 0, tag);
    cycle(4'b0010, 1, 0, 0, tag);
    cycle(4'b0100, 1, 0, 0, tag);
    cycle(4'b1000, 1, 0, 0, tag);
    cycle(4'b0001, 1, 0, 0, tag);
  endtask

  // Monitor: compare after every rising edge that has a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (ifc.io_out === e.exp) passes++;
        else $display("FAIL %s: io_out=%02h expected %02h", e.tag, ifc.io_out, e.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph;
    int r;
    logic [3:0] l;
    bit se, clr, rst;
    model_reset();

    cycle(4'b0000, 0, 0, 1, "reset");
    cycle(4'b0000, 0, 0, 1, "reset");

    lock_seq("lock");
    cycle(4'b0010, 1, 0, 0, "run_adv1");
    cycle(4'b0100, 1, 0, 0, "run_adv2");

    cycle(4'b0001, 1, 0, 0, "skip_err");
    cycle(4'b0011, 1, 0, 0, "hunt_multihot");
    cycle(4'b0000, 1, 0, 0, "hunt_zero");

    lock_seq("relock_a");
    cycle(4'b0010, 1, 0, 0, "to_phase1");
    for (int unsigned i = 0; i < 15; i++) cycle(4'b0010, 1, 0, 0, "stall15");
    cycle(4'b0010, 1, 0, 0, "post_stall");

    cycle(4'b0000, 1, 0, 0, "idle");
    lock_seq("relock_b");
    cycle(4'b0010, 1, 0, 0, "to_phase1b");
    for (int unsigned i = 0; i < 14; i++) cycle(4'b0010, 1, 0, 0, "hold14");
    cycle(4'b0100, 1, 0, 0, "hold14_adv");
    cycle(4'b1000, 1, 0, 0, "hold14_adv2");

    for (int unsigned i = 0; i < 9; i++) begin
      cycle(4'b0000, 1, 0, 0, "sat_idle");
      lock_seq("sat_lock");
      cycle(4'b0100, 1, 0, 0, "sat_err");
    end
    cycle(4'b0000, 1, 0, 0, "sat_idle");
    lock_seq("clr_lock");
    cycle(4'b0100, 1, 1, 0, "clr_with_err");
    cycle(4'b0000, 0, 1, 0, "clr_alone");
    cycle(4'b1111, 0, 0, 0, "se0_garbage");
    cycle(4'b0101, 0, 0, 0, "se0_garbage");
    lock_seq("se0_lock");
    cycle(4'b1010, 0, 0, 0, "se0_locked_garbage");
    cycle(4'b0010, 1, 0, 0, "se1_after_gap");

    cycle(4'b0100, 1, 0, 1, "rst_mid_locked", 1'b1);
    cycle(4'b0100, 1, 0, 1, "rst_hold");
    cycle(4'b0100, 1, 0, 0, "rst_release");

    ph = 0;
    for (int unsigned n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) begin
        ph = (ph + 1) % 4;
        l = 4'(1 << ph);
      end else if (r < 85) begin
        l = 4'(1 << ph);
      end else if (r < 93) begin
        ph = int'($urandom_range(0, 3));
        l = 4'(1 << ph);
      end else begin
        l = 4'($urandom_range(0, 15));
      end
      se  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 399) == 0);
      cycle(l, se, clr, rst, "random");
    end

    @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() == 0) passes++;
    else $display("FAIL drain: pending=%0d expected 0", sb_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
